// File: rtl/fifo_read_accum.sv
// fifo_read_accum: on a start pulse, pops a run-time number of words from a FIFO read port
// and reduces them (LAST, SUM or unsigned MAX) into one registered result. The result is
// presented with valid until the next start is accepted.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             run request, accepted only when idle or done
//   count             words to pop this run (0 completes immediately with result 0)
//   mode              0/3 = LAST, 1 = SUM (wrapping), 2 = MAX (unsigned)
//   fifo_in_data      write data to FIFO, tied to 0
//   fifo_read_valid   one-cycle pop request per word
//   fifo_rst          FIFO reset, tied to 0
//   fifo_write_valid  FIFO write request, tied to 0
//   fifo_out_data     FIFO read data, valid the cycle after fifo_read_valid
//   fifo_read_ready   FIFO non-empty
//   fifo_write_ready  unused
//   return_value      reduced result, stable while valid
//   valid             result available
//   busy              run in progress
module fifo_read_accum #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] count,
   input  logic [1:0]             mode,
   output logic [DATA_WIDTH-1:0]  fifo_in_data,
   output logic                   fifo_read_valid,
   output logic                   fifo_rst,
   output logic                   fifo_write_valid,
   input  logic [DATA_WIDTH-1:0]  fifo_out_data,
   input  logic                   fifo_read_ready,
   input  logic                   fifo_write_ready,
   output logic [DATA_WIDTH-1:0]  return_value,
   output logic                   valid,
   output logic                   busy
);

   typedef enum logic [2:0] {StIdle, StWait, StReq, StCap, StDone} state_e;

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  acc_q, acc_d;
   logic [DATA_WIDTH-1:0]  result_q, result_d;
   logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [1:0]             mode_q, mode_d;
   logic [DATA_WIDTH-1:0]  reduced;
   logic                   unused_write_ready;

   // Write side of the FIFO is never used.
   assign fifo_in_data       = '0;
   assign fifo_rst           = 1'b0;
   assign fifo_write_valid   = 1'b0;
   assign unused_write_ready = fifo_write_ready;

   // Reduction of the running accumulator with the word captured this cycle.
   // MAX needs no first-word special case since acc starts at 0.
   always_comb begin
      case (mode_q)
         2'd1:    reduced = acc_q + fifo_out_data;
         2'd2:    reduced = (fifo_out_data > acc_q) ? fifo_out_data : acc_q;
         default: reduced = fifo_out_data;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         result_q    <= '0;
         remaining_q <= '0;
         mode_q      <= 2'd0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         remaining_q <= remaining_d;
         mode_q      <= mode_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      result_d    = result_q;
      remaining_d = remaining_q;
      mode_d      = mode_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               mode_d      = mode;
               acc_d       = '0;
               remaining_d = count;
               if (count == '0) begin
                  state_d  = StDone;
                  result_d = '0;
               end else begin
                  state_d  = StWait;
               end
            end
         end
         StWait: begin
            if (fifo_read_ready) state_d = StReq;
         end
         StReq: begin
            state_d = StCap;
         end
         StCap: begin
            acc_d       = reduced;
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            if (remaining_q == COUNT_WIDTH'(1)) begin
               state_d  = StDone;
               result_d = reduced;
            end else if (fifo_read_ready) begin
               state_d  = StReq;
            end else begin
               state_d  = StWait;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs; the pop request is masked by rst so no pop escapes in a reset cycle.
   always_comb begin
      fifo_read_valid = (state_q == StReq) && !rst;
      valid           = (state_q == StDone);
      busy            = (state_q == StWait) || (state_q == StReq) || (state_q == StCap);
      return_value    = result_q;
   end

endmodule
